// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for the elastic pipe stage
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 2;
  localparam int RD_W_DEF   = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one payload register with its valid bit
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_valid_nxt,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Payload only changes on an explicit load; valid follows the owner's next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid_nxt;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry elastic pipeline register (main + skid) with flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CTRL_W       = CTRL_W_DEF,
  parameter int RD_W         = RD_W_DEF,
  parameter int ZERO_INVALID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  localparam int PL_W = CTRL_W + 2 * DATA_W + RD_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_load;
  logic              w_skid_load;
  logic              w_main_from_skid;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic [PL_W-1:0]   w_in_pl;
  logic [PL_W-1:0]   w_main_d;
  logic [PL_W-1:0]   w_main_pl;
  logic [PL_W-1:0]   w_skid_pl;
  logic [CTRL_W-1:0] w_main_ctrl;

  assign w_in_pl    = {in_ctrl, in_data0, in_data1, in_rd};
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_main_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ONE;
          w_main_load = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_load = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = TWO;
          w_skid_load = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_out_xfer) begin
          w_state_nxt      = ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush drops validity only; payload registers keep their old contents.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_pl : w_in_pl;

  pipe_entry #(.W(PL_W)) u_main (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_main_load),
    .i_data      (w_main_d),
    .i_valid_nxt (w_state_nxt != EMPTY),
    .o_valid     (w_main_valid),
    .o_data      (w_main_pl)
  );

  pipe_entry #(.W(PL_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_skid_load),
    .i_data      (w_in_pl),
    .i_valid_nxt (w_state_nxt == TWO),
    .o_valid     (w_skid_valid),
    .o_data      (w_skid_pl)
  );

  // Ready is the inverted skid valid flop, so it never sees out_ready combinationally.
  assign in_ready  = ~w_skid_valid;
  assign out_valid = w_main_valid;
  assign {w_main_ctrl, out_data0, out_data1, out_rd} = w_main_pl;
  assign out_ctrl  = (ZERO_INVALID != 0 && !w_main_valid) ? '0 : w_main_ctrl;
  assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for the elastic pipe stage
module tb_pipe_stage_reg;

  typedef logic [70:0] pl_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_ctrl, out_ctrl, occupancy;
  logic [31:0] in_data0, in_data1, out_data0, out_data1;
  logic [4:0]  in_rd, out_rd;
  pl_t         w_out_pl;
  pl_t         sb[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data0(in_data0), .in_data1(in_data1), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data0(out_data0), .out_data1(out_data1), .out_rd(out_rd),
    .occupancy(occupancy)
  );

  assign w_out_pl = {out_ctrl, out_data0, out_data1, out_rd};

  function automatic pl_t mk(input logic [1:0] c, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [4:0] rd);
    return {c, d0, d1, rd};
  endfunction

  task automatic set_in(input logic v, input pl_t p);
    in_valid = v;
    {in_ctrl, in_data0, in_data1, in_rd} = p;
  endtask

  // Called at the negedge once inputs are set: models the transfers of the coming edge.
  task automatic sb_track(output bit popped, output pl_t exp);
    popped = 1'b0;
    exp    = 'x;
    if (out_valid && out_ready) begin
      popped = 1'b1;
      if (sb.size() > 0) exp = sb.pop_front();
    end
    if (in_valid && in_ready && !flush) sb.push_back({in_ctrl, in_data0, in_data1, in_rd});
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, '0);
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (w_out_pl !== '0) $display("FAIL reset_payload: got %h want 0", w_out_pl); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    bit   popped;
    pl_t  exp;
    logic exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_in(i < 8, mk(2'b01, 32'(i + 1), 32'hC0DE0000 + 32'(i), 5'(i)));
      exp_v = (i >= 1 && i <= 8);
      n_checks++; if (out_valid !== exp_v) $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_checks++; if (out_data0 !== 32'(i)) $display("FAIL stream_order[%0d]: got %h want %h", i, out_data0, 32'(i)); else n_pass++;
      end
      sb_track(popped, exp);
      if (popped) begin
        n_checks++; if (w_out_pl !== exp) $display("FAIL stream_data: got %h want %h", w_out_pl, exp); else n_pass++;
      end
      @(negedge clk);
    end
    set_in(1'b0, '0);
    n_checks++; if (sb.size() != 0) $display("FAIL stream_drain: got %0d left want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit  popped;
    pl_t exp;
    pl_t a = mk(2'b01, 32'hA, 32'h1A, 5'd10);
    pl_t b = mk(2'b01, 32'hB, 32'h1B, 5'd11);
    out_ready = 1'b0;
    set_in(1'b1, a); sb_track(popped, exp); @(negedge clk);
    set_in(1'b1, b);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", in_ready); else n_pass++;
    sb_track(popped, exp); @(negedge clk);
    set_in(1'b0, '0);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (w_out_pl !== a) $display("FAIL bp_head: got %h want %h", w_out_pl, a); else n_pass++;
    sb_track(popped, exp); @(negedge clk);
    n_checks++; if (w_out_pl !== a) $display("FAIL bp_stall_hold: got %h want %h", w_out_pl, a); else n_pass++;
    out_ready = 1'b1;
    sb_track(popped, exp);
    n_checks++; if (!popped || w_out_pl !== exp || exp !== a) $display("FAIL bp_out_a: got %h want %h", w_out_pl, a); else n_pass++;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (occupancy !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", occupancy); else n_pass++;
    sb_track(popped, exp);
    n_checks++; if (!popped || w_out_pl !== exp || exp !== b) $display("FAIL bp_out_b: got %h want %h", w_out_pl, b); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    bit popped;
    pl_t exp;
    out_ready = 1'b0;
    set_in(1'b1, mk(2'b11, 32'h11, 32'h0, 5'd1)); sb_track(popped, exp); @(negedge clk);
    set_in(1'b1, mk(2'b11, 32'h22, 32'h0, 5'd2)); sb_track(popped, exp); @(negedge clk);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy); else n_pass++;
    flush = 1'b1;
    set_in(1'b1, mk(2'b11, 32'h77, 32'h0, 5'd7));
    @(negedge clk);
    flush = 1'b0; set_in(1'b0, '0); sb.delete();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (out_ctrl !== 2'b00) $display("FAIL flush_ctrl: got %b want 00", out_ctrl); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_data0 !== 32'h11) $display("FAIL flush_payload_kept: got %h want 11", out_data0); else n_pass++;
    // Flush from ONE while an input transfer would otherwise happen.
    out_ready = 1'b1;
    set_in(1'b1, mk(2'b01, 32'h88, 32'h0, 5'd8)); @(negedge clk);
    flush = 1'b1; out_ready = 1'b0;
    set_in(1'b1, mk(2'b01, 32'h99, 32'h0, 5'd9)); @(negedge clk);
    flush = 1'b0; set_in(1'b0, '0); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost[%0d]: got %b want 0", i, out_valid); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_bubble();
    bit  popped;
    pl_t exp;
    out_ready = 1'b1;
    set_in(1'b1, mk(2'b11, 32'h33, 32'h44, 5'd3)); sb_track(popped, exp); @(negedge clk);
    set_in(1'b0, mk(2'b11, 32'h0, 32'h0, 5'd0));
    n_checks++; if (out_ctrl !== 2'b11) $display("FAIL bubble_live_ctrl: got %b want 11", out_ctrl); else n_pass++;
    sb_track(popped, exp);
    n_checks++; if (!popped || w_out_pl !== exp) $display("FAIL bubble_data: got %h want %h", w_out_pl, exp); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00)
        $display("FAIL bubble_ctrl[%0d]: got valid %b ctrl %b want 0 00", i, out_valid, out_ctrl); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    bit  popped;
    pl_t exp;
    pl_t e = mk(2'b01, 32'h55, 32'h56, 5'd5);
    out_ready = 1'b0;
    set_in(1'b1, mk(2'b11, 32'h5A, 32'h1, 5'd1)); sb_track(popped, exp); @(negedge clk);
    set_in(1'b1, mk(2'b11, 32'h5B, 32'h2, 5'd2)); sb_track(popped, exp); @(negedge clk);
    set_in(1'b0, '0);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL ar_pre_occ: got %0d want 2", occupancy); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL ar_state: got valid %b occ %0d ready %b want 0 0 1", out_valid, occupancy, in_ready); else n_pass++;
    n_checks++; if (w_out_pl !== '0) $display("FAIL ar_payload: got %h want 0", w_out_pl); else n_pass++;
    sb.delete();
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    set_in(1'b1, e); sb_track(popped, exp); @(negedge clk);
    set_in(1'b0, '0);
    n_checks++; if (out_valid !== 1'b1 || w_out_pl !== e) $display("FAIL ar_first: got %b %h want 1 %h", out_valid, w_out_pl, e); else n_pass++;
    sb_track(popped, exp); @(negedge clk);
  endtask

  task automatic test_random();
    bit   popped, prev_stall;
    pl_t  exp, prev_pl;
    int   bad_occ, bad_rdy, bad_stall, bad_data;
    prev_stall = 1'b0; prev_pl = '0;
    bad_occ = 0; bad_rdy = 0; bad_stall = 0; bad_data = 0;
    for (int c = 0; c < 10000; c++) begin
      set_in($urandom_range(0, 3) != 0, mk(2'($urandom), $urandom, $urandom, 5'($urandom)));
      out_ready = (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      n_checks++; if (int'(occupancy) != sb.size()) begin
        if (bad_occ++ < 5) $display("FAIL rand_occ[%0d]: got %0d want %0d", c, occupancy, sb.size());
      end else n_pass++;
      n_checks++; if (in_ready !== (sb.size() < 2)) begin
        if (bad_rdy++ < 5) $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, sb.size() < 2);
      end else n_pass++;
      if (prev_stall) begin
        n_checks++; if (out_valid !== 1'b1 || w_out_pl !== prev_pl) begin
          if (bad_stall++ < 5) $display("FAIL rand_stall[%0d]: got %h want %h", c, w_out_pl, prev_pl);
        end else n_pass++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pl    = w_out_pl;
      sb_track(popped, exp);
      if (popped) begin
        n_checks++; if (w_out_pl !== exp) begin
          if (bad_data++ < 5) $display("FAIL rand_data[%0d]: got %h want %h", c, w_out_pl, exp);
        end else n_pass++;
      end
      @(negedge clk);
    end
    set_in(1'b0, '0); out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sb_track(popped, exp);
      if (popped) begin
        n_checks++; if (w_out_pl !== exp) $display("FAIL rand_drain_data: got %h want %h", w_out_pl, exp); else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rand_drain: got %0d left valid %b want 0 0", sb.size(), out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
